// File: rtl/class_gen_ctrl_if.sv
// Sample handshake between the HDC sample encoder and class_gen_ctrl.
//   master : encoder side, drives sample_valid / labels / retrain_mode, sees sample_ready
//   slave  : controller side, sees the sample, drives sample_ready
interface class_gen_ctrl_if #(
  parameter int CLS_W = 5
);
  logic             sample_valid;
  logic [CLS_W-1:0] sample_label;
  logic             retrain_mode;
  logic [CLS_W-1:0] pred_label;
  logic             sample_ready;

  modport master (
    output sample_valid, sample_label, retrain_mode, pred_label,
    input  sample_ready
  );

  modport slave (
    input  sample_valid, sample_label, retrain_mode, pred_label,
    output sample_ready
  );
endinterface

// File: rtl/class_gen_ctrl.sv
// Class-hypervector generation sequencer for the sparse HDC trainer.
// Walks encoded sample HVs segment by segment into the class accumulator
// (add to true class, optionally subtract from mispredicted class), then
// binarizes every class HV segment by segment.
// Ports:
//   clk, nrst        clock, synchronous active-low reset
//   en               global enable / stall
//   smp              sample handshake (valid/ready, labels, retrain_mode)
//   binarize_start   begin binarization (IDLE only)
//   clear            leave DONE for a new training run
//   seg_idx          current segment index
//   acc_class/op/we  accumulator update strobe (op 0 add, 1 subtract)
//   bin_class/we     binarized-memory write strobe
//   label_err        pulse: out-of-range label dropped
//   busy             sequencing in progress
//   class_gen_done   level, high while in DONE
//
// state      | meaning
// -----------+--------------------------------------------------
// S_IDLE     | waiting for a sample or binarize_start
// S_ACC_ADD  | adding sample segments into the true class
// S_ACC_SUB  | subtracting sample segments from predicted class
// S_BINARIZE | binarizing every class, segment by segment
// S_DONE     | binarization complete, waiting for clear
module class_gen_ctrl #(
  parameter int NUM_CLASSES = 26,
  parameter int SEG_COUNT   = 10,
  parameter int SEG_W       = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1,
  parameter int CLS_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  class_gen_ctrl_if.slave     smp,
  input  logic                binarize_start,
  input  logic                clear,
  output logic [SEG_W-1:0]    seg_idx,
  output logic [CLS_W-1:0]    acc_class,
  output logic                acc_op,
  output logic                acc_we,
  output logic [CLS_W-1:0]    bin_class,
  output logic                bin_we,
  output logic                label_err,
  output logic                busy,
  output logic                class_gen_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACC_ADD, S_ACC_SUB, S_BINARIZE, S_DONE
  } state_t;

  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_COUNT - 1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);
  // One extra bit so the range check works when NUM_CLASSES == 2**CLS_W.
  localparam logic [CLS_W:0]   NCLS     = (CLS_W + 1)'(NUM_CLASSES);

  state_t           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [CLS_W-1:0] bin_q, bin_d;
  logic [CLS_W-1:0] true_q, true_d;
  logic [CLS_W-1:0] pred_q, pred_d;
  logic             rtr_q, rtr_d;
  logic             lerr_q, lerr_d;

  logic ready;
  logic accept;
  logic bad_label;

  assign ready            = en && (state_q == S_IDLE) && !binarize_start;
  assign smp.sample_ready = ready;
  assign accept           = smp.sample_valid && ready;
  assign bad_label        = ({1'b0, smp.sample_label} >= NCLS) ||
                            (smp.retrain_mode && ({1'b0, smp.pred_label} >= NCLS));

  always_comb begin
    state_d        = state_q;
    seg_d          = seg_q;
    bin_d          = bin_q;
    true_d         = true_q;
    pred_d         = pred_q;
    rtr_d          = rtr_q;
    lerr_d         = 1'b0;
    acc_class      = '0;
    acc_op         = 1'b0;
    acc_we         = 1'b0;
    bin_we         = 1'b0;
    busy           = 1'b0;
    class_gen_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && binarize_start) begin
          state_d = S_BINARIZE;
        end else if (accept) begin
          true_d = smp.sample_label;
          pred_d = smp.pred_label;
          rtr_d  = smp.retrain_mode;
          if (bad_label) begin
            lerr_d = 1'b1;
          end else if (!(smp.retrain_mode && (smp.sample_label == smp.pred_label))) begin
            state_d = S_ACC_ADD;
          end
        end
      end

      S_ACC_ADD, S_ACC_SUB: begin
        busy      = 1'b1;
        acc_class = (state_q == S_ACC_ADD) ? true_q : pred_q;
        acc_op    = (state_q == S_ACC_SUB);
        acc_we    = en;
        if (en) begin
          if (seg_q == SEG_LAST) begin
            seg_d   = '0;
            state_d = (state_q == S_ACC_ADD && rtr_q) ? S_ACC_SUB : S_IDLE;
          end else begin
            seg_d = seg_q + SEG_W'(1);
          end
        end
      end

      S_BINARIZE: begin
        busy   = 1'b1;
        bin_we = en;
        if (en) begin
          if (seg_q == SEG_LAST) begin
            seg_d = '0;
            if (bin_q == CLS_LAST) begin
              bin_d   = '0;
              state_d = S_DONE;
            end else begin
              bin_d = bin_q + CLS_W'(1);
            end
          end else begin
            seg_d = seg_q + SEG_W'(1);
          end
        end
      end

      S_DONE: begin
        class_gen_done = 1'b1;
        if (en && clear) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      seg_q   <= '0;
      bin_q   <= '0;
      true_q  <= '0;
      pred_q  <= '0;
      rtr_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      bin_q   <= bin_d;
      true_q  <= true_d;
      pred_q  <= pred_d;
      rtr_q   <= rtr_d;
      lerr_q  <= lerr_d;
    end
  end

  assign seg_idx   = seg_q;
  assign bin_class = bin_q;
  assign label_err = lerr_q && en;

endmodule

// File: tb/tb_class_gen_ctrl.sv
module tb_class_gen_ctrl;
  localparam int NCLS  = 26;
  localparam int NSEG  = 10;
  localparam int SEG_W = 4;
  localparam int CLS_W = 5;

  logic             clk;
  logic             nrst;
  logic             en;
  logic             binarize_start;
  logic             clear;
  logic [SEG_W-1:0] seg_idx;
  logic [CLS_W-1:0] acc_class;
  logic             acc_op;
  logic             acc_we;
  logic [CLS_W-1:0] bin_class;
  logic             bin_we;
  logic             label_err;
  logic             busy;
  logic             class_gen_done;

  class_gen_ctrl_if #(.CLS_W(CLS_W)) smp ();

  class_gen_ctrl #(.NUM_CLASSES(NCLS), .SEG_COUNT(NSEG)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .smp            (smp),
    .binarize_start (binarize_start),
    .clear          (clear),
    .seg_idx        (seg_idx),
    .acc_class      (acc_class),
    .acc_op         (acc_op),
    .acc_we         (acc_we),
    .bin_class      (bin_class),
    .bin_we         (bin_we),
    .label_err      (label_err),
    .busy           (busy),
    .class_gen_done (class_gen_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int acc_exp[$];
  int bin_exp[$];
  int lerr_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe the DUT emits is matched against the oldest expectation.
  always @(negedge clk) begin
    if (nrst) begin
      if (acc_we) begin
        if (acc_exp.size() == 0) chk("acc_extra", 1, 0);
        else chk("acc_wr", 32'({acc_class, acc_op, seg_idx}), acc_exp.pop_front());
      end
      if (bin_we) begin
        if (bin_exp.size() == 0) chk("bin_extra", 1, 0);
        else chk("bin_wr", 32'({bin_class, seg_idx}), bin_exp.pop_front());
      end
      if (label_err) begin
        if (lerr_exp == 0) chk("lerr_extra", 1, 0);
        else begin
          chk("lerr_pulse", 32'(label_err), 1);
          lerr_exp--;
        end
      end
    end
  end

  // Starts in a posedge+1 context; returns at a negedge where sample_ready is high.
  task automatic run_sample(input int lab, input int pred, input bit rm,
                            input int exp_lat, input bit do_stall);
    int  lat;
    bit  stalled;
    bit  bad;
    stalled = 0;
    @(posedge clk); #1;
    smp.sample_valid = 1'b1;
    smp.sample_label = CLS_W'(lab);
    smp.pred_label   = CLS_W'(pred);
    smp.retrain_mode = rm;
    bad = (lab >= NCLS) || (rm && pred >= NCLS);
    if (bad) lerr_exp++;
    else if (!(rm && lab == pred)) begin
      for (int s = 0; s < NSEG; s++) acc_exp.push_back((lab << 5) | s);
      if (rm) for (int s = 0; s < NSEG; s++) acc_exp.push_back((pred << 5) | (1 << 4) | s);
    end
    @(negedge clk);
    chk("ready_pre", 32'(smp.sample_ready), 1);
    @(posedge clk); #1;
    smp.sample_valid = 1'b0;
    lat = 1;
    while (lat < 200) begin
      if (do_stall && !stalled && seg_idx == 4 && acc_we) begin
        stalled = 1;
        en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_we", 32'(acc_we), 0);
          chk("stall_seg", 32'(seg_idx), 4);
          @(posedge clk); #1;
          lat++;
        end
        en = 1'b1;
      end
      @(negedge clk);
      if (smp.sample_ready) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({seg_idx, acc_class, acc_op, acc_we, bin_class, bin_we,
                  label_err, busy, class_gen_done, smp.sample_ready}), 0);
  endtask

  initial begin
    int lat;
    nrst = 1'b0; en = 1'b0; binarize_start = 1'b0; clear = 1'b0;
    smp.sample_valid = 1'b0; smp.sample_label = '0;
    smp.pred_label = '0; smp.retrain_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    chk_all_zero("reset_outs");
    @(posedge clk); #1;
    en = 1'b1;
    @(negedge clk);
    chk("ready_idle", 32'(smp.sample_ready), 1);

    // plain accumulate, boundary labels, retrain, equal labels, bad labels, stall
    run_sample(3,  0,  1'b0, NSEG + 1, 1'b0);
    run_sample(0,  0,  1'b0, NSEG + 1, 1'b0);
    run_sample(25, 0,  1'b0, NSEG + 1, 1'b0);
    run_sample(5,  12, 1'b1, 2*NSEG + 1, 1'b0);
    run_sample(5,  5,  1'b1, 1, 1'b0);
    run_sample(26, 0,  1'b0, 1, 1'b0);
    run_sample(4,  30, 1'b1, 1, 1'b0);
    run_sample(31, 2,  1'b0, 1, 1'b0);
    run_sample(25, 0,  1'b1, 2*NSEG + 1, 1'b0);
    run_sample(3,  0,  1'b0, NSEG + 4, 1'b1);

    // binarize_start beats a simultaneous sample
    @(posedge clk); #1;
    binarize_start = 1'b1;
    smp.sample_valid = 1'b1; smp.sample_label = 5'd2; smp.retrain_mode = 1'b0;
    for (int c = 0; c < NCLS; c++)
      for (int s = 0; s < NSEG; s++) bin_exp.push_back((c << 4) | s);
    @(negedge clk);
    chk("ready_binstart", 32'(smp.sample_ready), 0);
    @(posedge clk); #1;
    binarize_start = 1'b0;
    lat = 1;
    while (lat < 400) begin
      @(negedge clk);
      if (class_gen_done) break;
      @(posedge clk); #1;
      lat++;
    end
    chk("bin_latency", lat, NCLS*NSEG + 1);
    chk("bin_left", bin_exp.size(), 0);
    chk("acc_left_bin", acc_exp.size(), 0);
    chk("done_busy", 32'(busy), 0);
    chk("done_ready", 32'(smp.sample_ready), 0);
    @(posedge clk); #1;
    smp.sample_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_done", 32'(class_gen_done), 0);
    chk("clear_ready", 32'(smp.sample_ready), 1);

    // reset in the middle of binarization
    @(posedge clk); #1;
    binarize_start = 1'b1;
    for (int c = 0; c < NCLS; c++)
      for (int s = 0; s < NSEG; s++) bin_exp.push_back((c << 4) | s);
    @(posedge clk); #1;
    binarize_start = 1'b0;
    lat = 0;
    while (bin_class != 5'd7 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bin_reach7", 32'(bin_class), 7);
    chk("bin_busy", 32'(busy), 1);
    nrst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    bin_exp.delete();
    @(negedge clk);
    chk_all_zero("midrun_reset");
    @(posedge clk); #1;
    nrst = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(smp.sample_ready), 1);
    chk("post_rst_seg", 32'({bin_class, seg_idx}), 0);
    run_sample(7, 0, 1'b0, NSEG + 1, 1'b0);

    chk("acc_left", acc_exp.size(), 0);
    chk("lerr_left", lerr_exp, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
